// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: row-scan driver for a ROWS x COLS LED dot matrix.
// Holds FRAMES frames in an internal buffer. Shows one frame statically,
// animates through all frames, or scrolls one frame left. Includes its own
// scan prescaler.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-low
//   mode       00 static, 01 animate, 10 scroll, 11 blank
//   sel_frame  frame shown in static/scroll mode
//   wr_en      buffer write strobe, one word per clk
//   wr_frame   write frame index
//   wr_row     write row index
//   wr_data    row pixels, bit c = column c, 1 = lit
//   dot_row    row select, active-low one-hot (row 0 drives the MSB)
//   dot_col    column data, active-high
//   frame_done 1-clk pulse while the last row is driven
module led_matrix_scanner #(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLS     = 8,
  parameter int unsigned FRAMES   = 4,
  parameter int unsigned SCAN_DIV = 5000,
  parameter int unsigned HOLD     = 64,
  localparam int unsigned FW      = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int unsigned RW      = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mode,
  input  logic [FW-1:0]   sel_frame,
  input  logic            wr_en,
  input  logic [FW-1:0]   wr_frame,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  output logic [ROWS-1:0] dot_row,
  output logic [COLS-1:0] dot_col,
  output logic            frame_done
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned OW = $clog2(COLS);
  localparam int unsigned SW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_ANIM   = 2'b01,
    MODE_SCROLL = 2'b10,
    MODE_BLANK  = 2'b11
  } mode_e;

  logic [COLS-1:0]   mem [FRAMES][ROWS];

  logic [PW-1:0]     pre_cnt;
  logic              tick;
  logic [RW-1:0]     row_idx;
  logic              last_row;
  logic [FW-1:0]     frame,  frame_nx;
  logic [OW-1:0]     offset, offset_nx;
  logic [SW-1:0]     step,   step_nx;
  mode_e             cur_mode, mode_nx, new_mode;
  logic              step_wrap;
  logic              wr_ok;

  logic [COLS-1:0]   src_word;
  logic [2*COLS-1:0] dbl_word;
  logic [COLS-1:0]   rot_word;
  logic [ROWS-1:0]   row_sel;

  assign tick     = (pre_cnt == PW'(SCAN_DIV - 1));
  assign last_row = (row_idx == RW'(ROWS - 1));
  assign new_mode = mode_e'(mode);

  // Rotate left by offset: doubling the word turns the wrap into a plain shift.
  assign src_word = mem[frame][row_idx];
  assign dbl_word = {src_word, src_word} << offset;
  assign rot_word = dbl_word[2*COLS-1:COLS];
  assign row_sel  = ~(ROWS'(1) << (RW'(ROWS - 1) - row_idx));

  // Writes to rows/frames that do not exist are dropped.
  assign wr_ok = ({1'b0, wr_row} < (RW + 1)'(ROWS)) &&
                 ({1'b0, wr_frame} < (FW + 1)'(FRAMES));

  // Frame buffer, not reset; reads see the pre-write word on a coincident clk.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) mem[wr_frame][wr_row] <= wr_data;
  end

  // Frame/offset/step sequencing, evaluated only at a frame boundary.
  always_comb begin
    frame_nx  = frame;
    offset_nx = offset;
    step_nx   = step;
    mode_nx   = cur_mode;
    step_wrap = (step == SW'(HOLD - 1));
    if (tick && last_row) begin
      mode_nx = new_mode;
      if (new_mode != cur_mode) begin
        step_nx   = '0;
        offset_nx = '0;
        if (new_mode == MODE_STATIC || new_mode == MODE_SCROLL) frame_nx = sel_frame;
      end else begin
        unique case (cur_mode)
          MODE_STATIC: begin
            frame_nx  = sel_frame;
            offset_nx = '0;
            step_nx   = '0;
          end
          MODE_ANIM: begin
            offset_nx = '0;
            step_nx   = step_wrap ? '0 : step + SW'(1);
            if (step_wrap)
              frame_nx = (frame == FW'(FRAMES - 1)) ? '0 : frame + FW'(1);
          end
          MODE_SCROLL: begin
            frame_nx = sel_frame;
            step_nx  = step_wrap ? '0 : step + SW'(1);
            if (step_wrap)
              offset_nx = (offset == OW'(COLS - 1)) ? '0 : offset + OW'(1);
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Prescaler, scan position, sequencing state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt    <= '0;
      row_idx    <= '0;
      frame      <= '0;
      offset     <= '0;
      step       <= '0;
      cur_mode   <= MODE_STATIC;
      dot_row    <= '1;
      dot_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      pre_cnt    <= tick ? '0 : pre_cnt + PW'(1);
      frame_done <= 1'b0;
      if (tick) begin
        dot_row    <= row_sel;
        dot_col    <= (cur_mode == MODE_BLANK) ? '0 : rot_word;
        frame_done <= last_row;
        row_idx    <= last_row ? '0 : row_idx + RW'(1);
      end
      frame    <= frame_nx;
      offset   <= offset_nx;
      step     <= step_nx;
      cur_mode <= mode_nx;
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: checks an 8x8/4-frame/HOLD=2 scanner against a
// frame-level reference model every clock, plus directed sequences. A second
// 6-row HOLD=1 instance shares the inputs for scroll and row-range cases.
module tb_led_matrix_scanner;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [1:0] sel_frame = 2'd0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_frame = 2'd0;
  logic [2:0] wr_row = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] dot_row, dot_col;
  logic       frame_done;
  logic [5:0] dot_row1;
  logic [7:0] dot_col1;
  logic       frame_done1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  led_matrix_scanner #(.ROWS(8), .COLS(8), .FRAMES(4), .SCAN_DIV(SD), .HOLD(2)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel_frame(sel_frame), .wr_en(wr_en),
    .wr_frame(wr_frame), .wr_row(wr_row), .wr_data(wr_data),
    .dot_row(dot_row), .dot_col(dot_col), .frame_done(frame_done));

  led_matrix_scanner #(.ROWS(6), .COLS(8), .FRAMES(4), .SCAN_DIV(SD), .HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .sel_frame(sel_frame), .wr_en(wr_en),
    .wr_frame(wr_frame), .wr_row(wr_row), .wr_data(wr_data),
    .dot_row(dot_row1), .dot_col(dot_col1), .frame_done(frame_done1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] v, input int o);
    logic [15:0] t;
    t = {8'h00, v} << o;
    return t[7:0] | t[15:8];
  endfunction

  // ---------------- reference model (frame level) ----------------
  logic [7:0] mm [4][8];
  int   m_pcnt = 0, m_row = 0, m_frame = 0, m_off = 0, m_step = 0, m_mode = 0, m_tickcnt = 0;
  bit   m_tick = 0;
  logic [7:0] exp_row = 8'hFF, exp_col = 8'h00;
  logic exp_fd = 1'b0;

  initial forever begin
    @(posedge clk);
    if (!rst) begin
      m_pcnt = 0; m_row = 0; m_frame = 0; m_off = 0; m_step = 0; m_mode = 0; m_tickcnt = 0;
      m_tick = 0; exp_row = 8'hFF; exp_col = 8'h00; exp_fd = 1'b0;
    end else begin
      m_tick = (m_pcnt == SD - 1);
      m_pcnt = m_tick ? 0 : m_pcnt + 1;
      exp_fd = 1'b0;
      if (m_tick) begin
        m_tickcnt++;
        exp_row = 8'hFF ^ (8'h80 >> m_row);
        exp_col = (m_mode == 3) ? 8'h00 : rotl(mm[m_frame][m_row], m_off);
        exp_fd  = (m_row == 7);
        if (m_row == 7) begin
          if (int'(mode) != m_mode) begin
            m_step = 0; m_off = 0;
            if (mode == 2'b00 || mode == 2'b10) m_frame = int'(sel_frame);
            m_mode = int'(mode);
          end else begin
            case (m_mode)
              0: begin m_frame = int'(sel_frame); m_off = 0; m_step = 0; end
              1: begin m_step = (m_step + 1) % 2; if (m_step == 0) m_frame = (m_frame + 1) % 4; end
              2: begin m_frame = int'(sel_frame); m_step = (m_step + 1) % 2;
                       if (m_step == 0) m_off = (m_off + 1) % 8; end
              default: ;
            endcase
          end
        end
        m_row = (m_row + 1) % 8;
      end
      if (wr_en) mm[wr_frame][wr_row] = wr_data;
    end
    #1;
    check("model_dot_row", 32'(dot_row), 32'(exp_row));
    check("model_dot_col", 32'(dot_col), 32'(exp_col));
    check("model_frame_done", 32'(frame_done), 32'(exp_fd));
  end

  // ---------------- helpers ----------------
  task automatic wait_tick();
    int n = 0;
    do begin
      @(posedge clk); #2; n++;
    end while (!m_tick && n < 4 * SD);
    if (!m_tick) begin n_tests++; n_fail++; $display("FAIL tick_timeout at %0t", $time); end
  endtask

  task automatic wait_boundary();
    int n = 0;
    do begin wait_tick(); n++; end while (!exp_fd && n < 20);
    if (!exp_fd) begin n_tests++; n_fail++; $display("FAIL boundary_timeout at %0t", $time); end
  endtask

  // Waits for the tick on which the 6-row instance registers its row 0.
  task automatic wait_row0_d1();
    int n = 0;
    do begin wait_tick(); n++; end while (((m_tickcnt - 1) % 6) != 0 && n < 14);
    if (((m_tickcnt - 1) % 6) != 0) begin
      n_tests++; n_fail++; $display("FAIL row0_timeout at %0t", $time);
    end
  endtask

  task automatic write_word(input int f, input int r, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_frame = 2'(f); wr_row = 3'(r); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  typedef struct { logic [7:0] wdata; logic [7:0] erow; } vec_t;
  vec_t tbl[8];
  logic [7:0] anim_exp[9];
  logic [7:0] scroll_exp[9];
  logic [7:0] d1_exp[6];
  logic [5:0] d1_row[6];

  initial begin
    #1000000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{'{8'h18, 8'h7F}, '{8'h24, 8'hBF}, '{8'h42, 8'hDF}, '{8'hC3, 8'hEF},
            '{8'h42, 8'hF7}, '{8'h42, 8'hFB}, '{8'h42, 8'hFD}, '{8'h7E, 8'hFE}};
    anim_exp   = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h04, 8'h04, 8'h08, 8'h08, 8'h01};
    scroll_exp = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
    d1_exp     = '{8'h81, 8'h24, 8'h42, 8'hC3, 8'h42, 8'h42};
    d1_row     = '{6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E};

    // Reset state
    #1 rst = 1'b0;
    #2;
    check("reset_dot_row", 32'(dot_row), 32'hFF);
    check("reset_dot_col", 32'(dot_col), 32'h00);
    check("reset_frame_done", 32'(frame_done), 32'h0);
    check("reset_dot_row1", 32'(dot_row1), 32'h3F);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Load buffer: frame 0 from the static table, other frames random
    for (int r = 0; r < 8; r++) write_word(0, r, tbl[r].wdata);
    for (int f = 1; f < 4; f++)
      for (int r = 0; r < 8; r++) write_word(f, r, 8'($urandom));

    // Static: two full scans follow the table
    wait_boundary();
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 8; r++) begin
        wait_tick();
        check("static_row", 32'(dot_row), 32'(tbl[r].erow));
        check("static_col", 32'(dot_col), 32'(tbl[r].wdata));
        check("static_fd", 32'(frame_done), (r == 7) ? 32'h1 : 32'h0);
      end

    // Animate: frame k row 0 = 1<<k, two scans per frame
    for (int k = 0; k < 4; k++) write_word(k, 0, 8'(1 << k));
    @(negedge clk); mode = 2'b01;
    wait_boundary();
    for (int i = 0; i < 9; i++) begin
      wait_tick();
      check("anim_row0_col", 32'(dot_col), 32'(anim_exp[i]));
      wait_boundary();
    end

    // Scroll on the HOLD=1 instance: one column per scan
    write_word(0, 0, 8'h81);
    wait_row0_d1();
    @(negedge clk); mode = 2'b10; sel_frame = 2'd0;
    for (int i = 0; i < 9; i++) begin
      wait_row0_d1();
      check("scroll_row0_col", 32'(dot_col1), 32'(scroll_exp[i]));
    end

    // Rows beyond ROWS-1 on the 6-row instance are not written
    @(negedge clk); mode = 2'b00;
    write_word(0, 6, 8'hFF);
    write_word(0, 7, 8'hFF);
    wait_row0_d1();
    wait_row0_d1();
    for (int r = 0; r < 6; r++) begin
      if (r != 0) wait_tick();
      check("range_row1", 32'(dot_row1), 32'(d1_row[r]));
      check("range_col1", 32'(dot_col1), 32'(d1_exp[r]));
    end

    // Write coinciding with the tick of the same row shows the old word
    write_word(0, 3, 8'h00);
    begin
      int n = 0;
      do begin wait_tick(); n++; end while (exp_row != 8'hDF && n < 20);
    end
    repeat (SD) @(negedge clk);
    wr_en = 1'b1; wr_frame = 2'd0; wr_row = 3'd3; wr_data = 8'hFF;
    @(posedge clk); #2;
    check("coinc_row", 32'(dot_row), 32'hEF);
    check("coinc_old_col", 32'(dot_col), 32'h00);
    @(negedge clk); wr_en = 1'b0;
    begin
      int n = 0;
      do begin wait_tick(); n++; end while (exp_row != 8'hEF && n < 20);
    end
    check("coinc_new_col", 32'(dot_col), 32'hFF);

    // Blank: columns dark for a whole frame, frame_done still pulses
    @(negedge clk); mode = 2'b11;
    wait_boundary();
    for (int r = 0; r < 8; r++) begin
      wait_tick();
      check("blank_col", 32'(dot_col), 32'h00);
      check("blank_fd", 32'(frame_done), (r == 7) ? 32'h1 : 32'h0);
    end
    check("blank_col1", 32'(dot_col1), 32'h00);

    // Random traffic, checked by the model each clock
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_frame = 2'($urandom);
      wr_row   = 3'($urandom);
      wr_data  = 8'($urandom);
      if ($urandom_range(0, 47) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 15) == 0) sel_frame = 2'($urandom);
    end
    @(negedge clk); wr_en = 1'b0; mode = 2'b00;

    // Asynchronous reset mid-scan, then prescaler restart
    @(negedge clk); #2 rst = 1'b0;
    #1;
    check("midreset_dot_row", 32'(dot_row), 32'hFF);
    check("midreset_dot_col", 32'(dot_col), 32'h00);
    check("midreset_fd", 32'(frame_done), 32'h0);
    check("midreset_dot_row1", 32'(dot_row1), 32'h3F);
    check("midreset_dot_col1", 32'(dot_col1), 32'h00);
    check("midreset_fd1", 32'(frame_done1), 32'h0);
    @(negedge clk); rst = 1'b1;
    repeat (SD - 1) @(posedge clk);
    #2 check("presc_before_first_tick", 32'(dot_row), 32'hFF);
    @(posedge clk); #2;
    check("presc_first_tick", 32'(dot_row), 32'h7F);
    repeat (SD) @(posedge clk);
    #2 check("presc_second_tick", 32'(dot_row), 32'hBF);
    repeat (100) @(posedge clk);
    #3;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
